// File: rtl/adder_rr_arbiter_pkg.sv
// Shared types and constants for the round-robin shared-adder arbiter.
package adder_rr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FULL = 1'b1
    } state_e;

    localparam int GRANT_CNT_W = 16;

endpackage

// File: rtl/adder_rr_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted request strictly after ptr,
// wrapping at NREQ; ptr itself is searched last.
module rr_picker #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant_oh,
    output logic [IDW-1:0]  grant_id,
    output logic            any
);

    int idx;

    // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
    always_comb begin
        grant_oh = '0;
        grant_id = '0;
        any      = 1'b0;
        idx      = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!any && req[idx]) begin
                any           = 1'b1;
                grant_oh[idx] = 1'b1;
                grant_id      = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/adder_rr_arbiter.sv
// Round-robin sequencer for one shared WIDTH-bit adder with a single-entry
// registered response port tagged by requester id.
module adder_rr_arbiter
    import adder_rr_arbiter_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int NREQ  = 4,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*WIDTH-1:0]  req_in0,
    input  logic [NREQ*WIDTH-1:0]  req_in1,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [WIDTH-1:0]       rsp_sum,
    output logic                   rsp_carry,
    output logic [GRANT_CNT_W-1:0] grant_cnt
);

    state_e           state_q, state_d;
    logic [IDW-1:0]   ptr_q;
    logic [NREQ-1:0]  grant_oh;
    logic [IDW-1:0]   grant_id;
    logic             any;
    logic             accept;
    logic [WIDTH-1:0] op_a, op_b;
    logic [WIDTH:0]   sum_w;

    rr_picker #(.NREQ(NREQ)) u_picker (
        .req      (req_valid),
        .ptr      (ptr_q),
        .grant_oh (grant_oh),
        .grant_id (grant_id),
        .any      (any)
    );

    assign op_a  = req_in0[int'(grant_id)*WIDTH +: WIDTH];
    assign op_b  = req_in1[int'(grant_id)*WIDTH +: WIDTH];
    assign sum_w = {1'b0, op_a} + {1'b0, op_b};

    assign rsp_valid = (state_q == ST_FULL);

    // A grant issues only when the response slot is empty or drains this cycle;
    // holding reset keeps any handshake from completing.
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        accept    = 1'b0;
        if (reset_n && (state_q == ST_IDLE || rsp_ready) && any) begin
            req_ready = grant_oh;
            accept    = 1'b1;
        end
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_FULL;
            ST_FULL: if (rsp_ready && !accept) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= IDW'(NREQ - 1);
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_carry <= 1'b0;
            grant_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                ptr_q                <= grant_id;
                rsp_id               <= grant_id;
                {rsp_carry, rsp_sum} <= sum_w;
                if (grant_cnt != '1) grant_cnt <= grant_cnt + GRANT_CNT_W'(1);
            end
        end
    end

    a_ready_onehot0 : assert property (@(posedge clock) disable iff (!reset_n)
        $onehot0(req_ready));
    a_ready_needs_valid : assert property (@(posedge clock) disable iff (!reset_n)
        ((req_ready & req_valid) === req_ready));

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Directed bench for adder_rr_arbiter with a per-id sum scoreboard and a
// one-hot-or-zero req_ready monitor.
module tb_adder_rr_arbiter;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;

    logic                   clock = 1'b0;
    logic                   reset_n;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*WIDTH-1:0]  req_in0;
    logic [NREQ*WIDTH-1:0]  req_in1;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [1:0]             rsp_id;
    logic [WIDTH-1:0]       rsp_sum;
    logic                   rsp_carry;
    logic [15:0]            grant_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] sum;
        logic       carry;
    } exp_t;

    exp_t sb_q[$];

    adder_rr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_in0   (req_in0),
        .req_in1   (req_in1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_carry (rsp_carry),
        .grant_cnt (grant_cnt)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard: snapshot just before each rising edge, when inputs are settled.
    always begin : monitor
        exp_t       e;
        logic [8:0] s;
        @(negedge clock);
        #4;
        total++;
        if (!$onehot0(req_ready)) begin
            bad++;
            $display("FAIL ready_onehot0: req_ready=%b", req_ready);
        end
        if (reset_n === 1'b1) begin
            if (rsp_valid && rsp_ready) begin
                total++;
                if (sb_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected: id=%0d sum=%0d with nothing outstanding", rsp_id, rsp_sum);
                end else begin
                    e = sb_q.pop_front();
                    if ({rsp_id, rsp_sum, rsp_carry} !== {e.id, e.sum, e.carry}) begin
                        bad++;
                        $display("FAIL sb_response: got id=%0d sum=%0d carry=%0d want id=%0d sum=%0d carry=%0d",
                                 rsp_id, rsp_sum, rsp_carry, e.id, e.sum, e.carry);
                    end
                end
            end
            for (int k = 0; k < NREQ; k++) begin
                if (req_valid[k] && req_ready[k]) begin
                    s       = {1'b0, req_in0[k*WIDTH +: WIDTH]} + {1'b0, req_in1[k*WIDTH +: WIDTH]};
                    e.id    = 2'(k);
                    e.sum   = s[7:0];
                    e.carry = s[8];
                    sb_q.push_back(e);
                end
            end
        end
    end

    always @(negedge reset_n) sb_q.delete();

    task automatic set_op(input int k, input logic [7:0] a, input logic [7:0] b);
        req_in0[k*WIDTH +: WIDTH] = a;
        req_in1[k*WIDTH +: WIDTH] = b;
    endtask

    // Requester k gets in0 = 16k+1, in1 = k+2, so its sum is 17k+3: 3, 20, 37, 54.
    task automatic set_table();
        for (int k = 0; k < NREQ; k++) set_op(k, 8'(k*16 + 1), 8'(k + 2));
    endtask

    task automatic drain();
        @(negedge clock);
        req_valid = '0;
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL drain_valid: got %0b want 0", rsp_valid); end
    endtask

    task automatic test_reset();
        reset_n   = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        req_in0   = '0;
        req_in1   = '0;
        #1 reset_n = 1'b0;
        req_valid = 4'($urandom);
        req_in0   = 32'($urandom);
        req_in1   = 32'($urandom);
        rsp_ready = 1'($urandom);
        repeat (3) @(negedge clock);
        #1;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", rsp_valid); end
        total++; if (rsp_id !== 2'd0) begin bad++; $display("FAIL reset_id: got %0d want 0", rsp_id); end
        total++; if (rsp_sum !== 8'd0) begin bad++; $display("FAIL reset_sum: got %0d want 0", rsp_sum); end
        total++; if (rsp_carry !== 1'b0) begin bad++; $display("FAIL reset_carry: got %0b want 0", rsp_carry); end
        total++; if (grant_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", grant_cnt); end
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
        req_valid = 4'b1111;
        set_table();
        rsp_ready = 1'b1;
        reset_n   = 1'b1;
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL release_ready: got %b want 0001", req_ready); end
        @(posedge clock); #1;
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL release_valid: got %0b want 1", rsp_valid); end
        total++; if (rsp_id !== 2'd0) begin bad++; $display("FAIL release_id: got %0d want 0", rsp_id); end
        total++; if (rsp_sum !== 8'd3) begin bad++; $display("FAIL release_sum: got %0d want 3", rsp_sum); end
        total++; if (grant_cnt !== 16'd1) begin bad++; $display("FAIL release_cnt: got %0d want 1", grant_cnt); end
        drain();
    endtask

    task automatic test_single();
        @(negedge clock);
        req_valid = 4'b0100;
        set_op(2, 8'd3, 8'd4);
        #1;
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_ready: got %b want 0100", req_ready); end
        @(posedge clock); #1;
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %0b want 1", rsp_valid); end
        total++; if (rsp_id !== 2'd2) begin bad++; $display("FAIL single_id: got %0d want 2", rsp_id); end
        total++; if (rsp_sum !== 8'd7) begin bad++; $display("FAIL single_sum: got %0d want 7", rsp_sum); end
        total++; if (rsp_carry !== 1'b0) begin bad++; $display("FAIL single_carry: got %0b want 0", rsp_carry); end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_id;
        @(negedge clock);
        req_valid = 4'b1000;
        set_table();
        #1;
        total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL b2b_pre_ready: got %b want 1000", req_ready); end
        @(posedge clock); #1;
        total++; if (rsp_id !== 2'd3) begin bad++; $display("FAIL b2b_pre_id: got %0d want 3", rsp_id); end
        @(negedge clock);
        req_valid = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #1;
            exp_id = 2'(i % 4);
            total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid[%0d]: got %0b want 1", i, rsp_valid); end
            total++; if (rsp_id !== exp_id) begin bad++; $display("FAIL b2b_id[%0d]: got %0d want %0d", i, rsp_id, exp_id); end
            total++; if (rsp_sum !== 8'(17*int'(exp_id) + 3)) begin
                bad++; $display("FAIL b2b_sum[%0d]: got %0d want %0d", i, rsp_sum, 17*int'(exp_id) + 3);
            end
        end
        drain();
    endtask

    task automatic test_carry();
        @(negedge clock);
        req_valid = 4'b0010;
        set_op(1, 8'd200, 8'd100);
        @(posedge clock); #1;
        total++; if (rsp_id !== 2'd1) begin bad++; $display("FAIL carry1_id: got %0d want 1", rsp_id); end
        total++; if (rsp_sum !== 8'd44) begin bad++; $display("FAIL carry1_sum: got %0d want 44", rsp_sum); end
        total++; if (rsp_carry !== 1'b1) begin bad++; $display("FAIL carry1_carry: got %0b want 1", rsp_carry); end
        @(negedge clock);
        set_op(1, 8'd255, 8'd1);
        @(posedge clock); #1;
        total++; if (rsp_sum !== 8'd0) begin bad++; $display("FAIL carry2_sum: got %0d want 0", rsp_sum); end
        total++; if (rsp_carry !== 1'b1) begin bad++; $display("FAIL carry2_carry: got %0b want 1", rsp_carry); end
        drain();
    endtask

    task automatic test_backpressure();
        @(negedge clock);
        req_valid = 4'b1111;
        set_table();
        rsp_ready = 1'b1;
        #1;
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL bp_first_ready: got %b want 0100", req_ready); end
        @(posedge clock); #1;
        total++; if (rsp_id !== 2'd2) begin bad++; $display("FAIL bp_first_id: got %0d want 2", rsp_id); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            rsp_ready = 1'b0;
            #1;
            total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL bp_stall_ready[%0d]: got %b want 0000", i, req_ready); end
            @(posedge clock); #1;
            total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_stall_valid[%0d]: got %0b want 1", i, rsp_valid); end
            total++; if (rsp_id !== 2'd2) begin bad++; $display("FAIL bp_stall_id[%0d]: got %0d want 2", i, rsp_id); end
            total++; if (rsp_sum !== 8'd37) begin bad++; $display("FAIL bp_stall_sum[%0d]: got %0d want 37", i, rsp_sum); end
        end
        @(negedge clock);
        rsp_ready = 1'b1;
        #1;
        total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL bp_resume_ready: got %b want 1000", req_ready); end
        @(posedge clock); #1;
        total++; if (rsp_id !== 2'd3) begin bad++; $display("FAIL bp_resume_id: got %0d want 3", rsp_id); end
        total++; if (rsp_sum !== 8'd54) begin bad++; $display("FAIL bp_resume_sum: got %0d want 54", rsp_sum); end
        total++; if (grant_cnt !== 16'd13) begin bad++; $display("FAIL bp_cnt: got %0d want 13", grant_cnt); end
        drain();
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        req_valid = 4'b0100;
        set_table();
        @(posedge clock); #1;
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid: got %0b want 1", rsp_valid); end
        #1 reset_n = 1'b0;
        #1;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %0b want 0", rsp_valid); end
        total++; if (grant_cnt !== 16'd0) begin bad++; $display("FAIL mid_cnt: got %0d want 0", grant_cnt); end
        total++; if (rsp_id !== 2'd0) begin bad++; $display("FAIL mid_id: got %0d want 0", rsp_id); end
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL mid_ready: got %b want 0000", req_ready); end
        @(negedge clock);
        reset_n   = 1'b1;
        req_valid = 4'b1111;
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL mid_release_ready: got %b want 0001", req_ready); end
        @(posedge clock); #1;
        total++; if (rsp_id !== 2'd0) begin bad++; $display("FAIL mid_release_id: got %0d want 0", rsp_id); end
        total++; if (grant_cnt !== 16'd1) begin bad++; $display("FAIL mid_release_cnt: got %0d want 1", grant_cnt); end
        drain();
    endtask

    task automatic test_saturate();
        @(negedge clock);
        reset_n = 1'b0;
        #1 reset_n = 1'b1;
        req_valid = 4'b1111;
        set_table();
        rsp_ready = 1'b1;
        repeat (65534) @(posedge clock);
        #1;
        total++; if (grant_cnt !== 16'hFFFE) begin bad++; $display("FAIL sat_below: got %h want fffe", grant_cnt); end
        @(posedge clock); #1;
        total++; if (grant_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_reach: got %h want ffff", grant_cnt); end
        repeat (3) @(posedge clock);
        #1;
        total++; if (grant_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_hold: got %h want ffff", grant_cnt); end
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL sat_valid: got %0b want 1", rsp_valid); end
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_carry();
        test_backpressure();
        test_reset_mid();
        test_saturate();
        repeat (2) @(posedge clock);
        #1;
        total++; if (sb_q.size() != 0) begin bad++; $display("FAIL sb_leftover: got %0d outstanding want 0", sb_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
